// File: rtl/adder_bist_checker.sv
// Exhaustive built-in self-test for an external 1-bit full adder: walks all 8 vectors, counts mismatches, captures the first failure.
// Optional checker self-test: define ADDER_BIST_FAULT_INJECT_EN to add fault_inj (inverts expected sum of vector 5).
module adder_bist_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef ADDER_BIST_FAULT_INJECT_EN
    input  logic                 fault_inj,
`endif
    output logic                 a_o,
    output logic                 b_o,
    output logic                 cin_o,
    input  logic                 sum_i,
    input  logic                 cout_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [2:0]           fail_vec
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SET_W-1:0]     SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0]    LOOP_LAST = LOOP_W'(LOOPS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state, state_nx;
    logic [2:0]            vec, vec_nx;
    logic [LOOP_W-1:0]     loop_cnt, loop_nx;
    logic [SET_W-1:0]      set_cnt, set_nx;
    logic [ERR_CNT_W-1:0]  err_nx;
    logic                  fail_valid_nx;
    logic [2:0]            fail_vec_nx;
    logic                  pass_nx;
    logic                  inj;
    logic                  exp_sum;
    logic                  exp_cout;
    logic                  mismatch;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic majority(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

`ifdef ADDER_BIST_FAULT_INJECT_EN
    // Injection request is latched together with an accepted start and held for the whole run.
    always_ff @(posedge clk) begin
        if (!rst_n)
            inj <= 1'b0;
        else if (state == IDLE && start)
            inj <= fault_inj;
    end
`else
    assign inj = 1'b0;
`endif

    assign exp_sum  = (^vec) ^ (inj && (vec == 3'd5));
    assign exp_cout = majority(vec);
    assign mismatch = (sum_i != exp_sum) || (cout_i != exp_cout);

    assign busy  = (state == SETTLE) || (state == CHECK);
    assign done  = (state == DONE);
    assign a_o   = busy & vec[2];
    assign b_o   = busy & vec[1];
    assign cin_o = busy & vec[0];

    always_comb begin
        state_nx      = state;
        vec_nx        = vec;
        loop_nx       = loop_cnt;
        set_nx        = set_cnt;
        err_nx        = err_count;
        fail_valid_nx = fail_valid;
        fail_vec_nx   = fail_vec;
        pass_nx       = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    err_nx        = '0;
                    fail_valid_nx = 1'b0;
                    fail_vec_nx   = 3'd0;
                    pass_nx       = 1'b0;
                    vec_nx        = 3'd0;
                    loop_nx       = '0;
                    set_nx        = '0;
                    state_nx      = SETTLE;
                end
            end
            SETTLE: begin
                if (set_cnt == SET_LAST)
                    state_nx = CHECK;
                else
                    set_nx = set_cnt + 1'b1;
            end
            CHECK: begin
                set_nx = '0;
                if (mismatch) begin
                    err_nx = sat_inc(err_count);
                    if (!fail_valid) begin
                        fail_valid_nx = 1'b1;
                        fail_vec_nx   = vec;
                    end
                end
                if (vec != 3'd7) begin
                    vec_nx   = vec + 3'd1;
                    state_nx = SETTLE;
                end else if (loop_cnt != LOOP_LAST) begin
                    vec_nx   = 3'd0;
                    loop_nx  = loop_cnt + 1'b1;
                    state_nx = SETTLE;
                end else begin
                    // Verdict is registered on entry to DONE so it is valid alongside the done pulse.
                    pass_nx  = (err_nx == '0);
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 3'd0;
            loop_cnt   <= '0;
            set_cnt    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nx;
            vec        <= vec_nx;
            loop_cnt   <= loop_nx;
            set_cnt    <= set_nx;
            err_count  <= err_nx;
            fail_valid <= fail_valid_nx;
            fail_vec   <= fail_vec_nx;
            pass       <= pass_nx;
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Scoreboard bench for adder_bist_checker: two instances with different parameters, each beside a faultable adder model.
module tb_adder_bist_checker;

    localparam int S0 = 2, L0 = 1, W0 = 4;
    localparam int S1 = 1, L1 = 2, W1 = 2;

    typedef struct {
        int err;
        int fv;
        int fvec;
        int pass;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       start_s [2];
    logic       inj_s   [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       cin_s   [2];
    logic       sum_s   [2];
    logic       cout_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic       fv_s    [2];
    logic [2:0] fvec_s  [2];
    logic [W0-1:0] err0;
    logic [W1-1:0] err1;

    int         mode_s  [2];
    logic [7:0] smask_s [2];
    logic [7:0] cmask_s [2];

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_bist_checker #(.SETTLE_CYCLES(S0), .LOOPS(L0), .ERR_CNT_W(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
`ifdef ADDER_BIST_FAULT_INJECT_EN
        .fault_inj(inj_s[0]),
`endif
        .a_o(a_s[0]), .b_o(b_s[0]), .cin_o(cin_s[0]), .sum_i(sum_s[0]), .cout_i(cout_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
        .fail_valid(fv_s[0]), .fail_vec(fvec_s[0])
    );

    adder_bist_checker #(.SETTLE_CYCLES(S1), .LOOPS(L1), .ERR_CNT_W(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
`ifdef ADDER_BIST_FAULT_INJECT_EN
        .fault_inj(inj_s[1]),
`endif
        .a_o(a_s[1]), .b_o(b_s[1]), .cin_o(cin_s[1]), .sum_i(sum_s[1]), .cout_i(cout_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
        .fail_valid(fv_s[1]), .fail_vec(fvec_s[1])
    );

    // Adder under test: value {cout,sum} as an integer; mode 0 good, 1 sum stuck-0, 2 cout stuck-1, 3 random flips.
    function automatic int adder_out(input int md, input logic [7:0] sm, input logic [7:0] cm, input logic [2:0] v);
        int r;
        r = int'(v[2]) + int'(v[1]) + int'(v[0]);
        case (md)
            1: r = r & 2;
            2: r = r | 2;
            3: r = r ^ (int'(cm[v]) * 2 + int'(sm[v]));
            default: r = r;
        endcase
        return r;
    endfunction

    always_comb {cout_s[0], sum_s[0]} = 2'(adder_out(mode_s[0], smask_s[0], cmask_s[0], {a_s[0], b_s[0], cin_s[0]}));
    always_comb {cout_s[1], sum_s[1]} = 2'(adder_out(mode_s[1], smask_s[1], cmask_s[1], {a_s[1], b_s[1], cin_s[1]}));

    function automatic int sp(input int i);  return (i == 0) ? S0 : S1; endfunction
    function automatic int lp(input int i);  return (i == 0) ? L0 : L1; endfunction
    function automatic int emax(input int i); return (i == 0) ? (1 << W0) - 1 : (1 << W1) - 1; endfunction
    function automatic int err_of(input int i); return (i == 0) ? int'(err0) : int'(err1); endfunction
    function automatic int qsize(input int i); return (i == 0) ? sb0.size() : sb1.size(); endfunction

    // Reference: a full adder's {cout,sum} is simply the count of ones among its three inputs.
    function automatic exp_t model(input int i, input int md, input logic [7:0] sm, input logic [7:0] cm, input bit inj);
        exp_t e;
        int n;
        int want;
        n = 0;
        e.fv = 0;
        e.fvec = 0;
        for (int p = 0; p < lp(i); p++) begin
            for (int k = 0; k < 8; k++) begin
                want = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
                if (inj && k == 5) want = want ^ 1;
                if (adder_out(md, sm, cm, 3'(k)) != want) begin
                    n++;
                    if (e.fv == 0) begin
                        e.fv = 1;
                        e.fvec = k;
                    end
                end
            end
        end
        e.err  = (n > emax(i)) ? emax(i) : n;
        e.pass = (n == 0) ? 1 : 0;
        e.cyc  = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && done_s[i]) begin
                if (qsize(i) == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", i), 1, 0);
                end else begin
                    exp_t e;
                    if (i == 0) e = sb0.pop_front();
                    else e = sb1.pop_front();
                    chk($sformatf("done_cycle_dut%0d", i), cyc, e.cyc);
                    chk($sformatf("err_count_dut%0d", i), err_of(i), e.err);
                    chk($sformatf("fail_valid_dut%0d", i), int'(fv_s[i]), e.fv);
                    chk($sformatf("fail_vec_dut%0d", i), int'(fvec_s[i]), e.fvec);
                    chk($sformatf("pass_dut%0d", i), int'(pass_s[i]), e.pass);
                    chk($sformatf("busy_at_done_dut%0d", i), int'(busy_s[i]), 0);
                end
            end
        end
    end

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("drain_timeout_dut%0d", i), qsize(i), 0);
        if (i == 0) sb0.delete();
        else sb1.delete();
    endtask

    task automatic run(input int i, input int md, input bit inj, input bit pulses, input bit hold);
        exp_t e;
        int c0;
        int t;
        mode_s[i] = md;
        if (md == 3) begin
            smask_s[i] = 8'($urandom);
            cmask_s[i] = 8'($urandom);
        end
        e = model(i, md, smask_s[i], cmask_s[i], inj);
        t = 8 * lp(i) * (sp(i) + 1);
        @(negedge clk);
        start_s[i] = 1'b1;
        inj_s[i] = inj;
        @(posedge clk);
        #1;
        c0 = cyc;
        e.cyc = c0 + t;
        push(i, e);
        if (!hold) start_s[i] = 1'b0;
        chk("busy_after_start", int'(busy_s[i]), 1);
        if (pulses) begin
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                start_s[i] = 1'b1;
                inj_s[i] = ~inj;
                @(posedge clk);
                #1;
                start_s[i] = 1'b0;
                inj_s[i] = inj;
            end
        end
        if (hold) begin
            repeat (t + 2) @(posedge clk);
            #1;
            e.cyc = c0 + 2 * t + 2;
            push(i, e);
            start_s[i] = 1'b0;
        end
        wait_idle(i);
        repeat (3) @(negedge clk);
        chk("held_err_count", err_of(i), e.err);
        chk("held_fail_vec", int'(fvec_s[i]), e.fvec);
        chk("held_pass", int'(pass_s[i]), e.pass);
        chk("idle_abc", int'({a_s[i], b_s[i], cin_s[i]}), 0);
    endtask

    task automatic check_cleared(input int i, input string tag);
        chk({tag, "_busy"}, int'(busy_s[i]), 0);
        chk({tag, "_done"}, int'(done_s[i]), 0);
        chk({tag, "_pass"}, int'(pass_s[i]), 0);
        chk({tag, "_err"}, err_of(i), 0);
        chk({tag, "_fail_valid"}, int'(fv_s[i]), 0);
        chk({tag, "_fail_vec"}, int'(fvec_s[i]), 0);
        chk({tag, "_abc"}, int'({a_s[i], b_s[i], cin_s[i]}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            inj_s[i] = 1'b0;
            mode_s[i] = 0;
            smask_s[i] = 8'd0;
            cmask_s[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_cleared(0, "reset0");
        check_cleared(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 1'b0, 1'b0, 1'b0);
        run(0, 1, 1'b0, 1'b0, 1'b0);
        run(0, 2, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) run(0, 3, 1'b0, 1'b0, 1'b0);

        // Abort a failing run mid-way: state must clear and no done may follow.
        mode_s[0] = 1;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_fail_valid", int'(fv_s[0]), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_cleared(0, "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        run(0, 0, 1'b0, 1'b0, 1'b0);

        run(0, 1, 1'b0, 1'b1, 1'b0);
        run(0, 2, 1'b0, 1'b0, 1'b1);

        run(1, 2, 1'b0, 1'b0, 1'b0);
        run(1, 0, 1'b0, 1'b0, 1'b0);
        run(1, 1, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) run(1, 3, 1'b0, 1'b0, 1'b0);

`ifdef ADDER_BIST_FAULT_INJECT_EN
        run(0, 0, 1'b1, 1'b1, 1'b0);
        run(0, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
